// File: rtl/fc_w_rd_sched.sv
// fc_w_rd_sched: dual-port weight BRAM read scheduler issuing two rows per cycle with RD_LAT-aligned valids.
module fc_w_rd_sched #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   row_cnt,
    input  logic              stall,
    output logic              fc_w_bram_ena,
    output logic [ADDR_W-1:0] fc_w_bram_addra,
    output logic              fc_w_bram_enb,
    output logic [ADDR_W-1:0] fc_w_bram_addrb,
    output logic              w_valid_a,
    output logic              w_valid_b,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;
    // every pipeline stage except the output stage: reads still on their way
    localparam logic [RD_LAT-1:0] PEND = RD_LAT'((1 << (RD_LAT - 1)) - 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   rem;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [RD_LAT-1:0] sr_a;
    logic [RD_LAT-1:0] sr_b;
    logic              issue;

    assign issue           = (state == ISSUE) && !stall;
    assign fc_w_bram_ena   = issue;
    assign fc_w_bram_enb   = issue && (rem > (ADDR_W+1)'(1));
    assign fc_w_bram_addra = addr_a;
    assign fc_w_bram_addrb = addr_b;
    assign w_valid_a       = sr_a[RD_LAT-1];
    assign w_valid_b       = sr_b[RD_LAT-1];
    assign busy            = (state == ISSUE) || (state == DRAIN);
    assign done            = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            addr_a <= '0;
            addr_b <= '0;
            sr_a   <= '0;
            sr_b   <= '0;
        end else begin
            sr_a <= RD_LAT'({sr_a, fc_w_bram_ena});
            sr_b <= RD_LAT'({sr_b, fc_w_bram_enb});
            if (state == IDLE && start) begin
                state  <= (row_cnt == '0) ? FIN : ISSUE;
                rem    <= row_cnt;
                addr_a <= base_addr;
                addr_b <= base_addr + ADDR_W'(1);
            end else if (issue) begin
                rem    <= rem - (ADDR_W+1)'(2);
                addr_a <= addr_a + ADDR_W'(2);
                addr_b <= addr_b + ADDR_W'(2);
                if (rem <= (ADDR_W+1)'(2)) state <= DRAIN;
            end else if (state == DRAIN && (sr_a & PEND) == '0) begin
                state <= FIN;
            end else if (state == FIN) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fc_w_rd_sched.sv
// tb_fc_w_rd_sched: randomized and directed checks of fc_w_rd_sched against a row-accounting model.
module tb_fc_w_rd_sched;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int NC  = 6000;

    logic          clk = 1'b0;
    logic          rst, start, stall;
    logic [AW-1:0] base_addr;
    logic [AW:0]   row_cnt;
    logic          fc_w_bram_ena, fc_w_bram_enb, w_valid_a, w_valid_b, busy, done;
    logic [AW-1:0] fc_w_bram_addra, fc_w_bram_addrb;

    fc_w_rd_sched #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_cnt(row_cnt),
        .stall(stall), .fc_w_bram_ena(fc_w_bram_ena), .fc_w_bram_addra(fc_w_bram_addra),
        .fc_w_bram_enb(fc_w_bram_enb), .fc_w_bram_addrb(fc_w_bram_addrb),
        .w_valid_a(w_valid_a), .w_valid_b(w_valid_b), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int t = 0;
    bit ha[NC], hb[NC];
    bit lena[NC], lenb[NC], lva[NC], lvb[NC], ldone[NC], lbusy[NC];
    logic [AW-1:0] la[NC], lb[NC];

    // model: a sweep is just rows left to hand out, rows handed out, and when the last one lands
    bit active = 0;
    bit prev_rst = 1;
    int rows_left = 0, issued = 0, m_base = 0;
    int last_valid = -100, done_cycle = -100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input int b, input int n, input bit st);
        bit e_ena, e_enb, idle;
        int k;
        rst = r; start = s; base_addr = AW'(b); row_cnt = (AW+1)'(n); stall = st;
        #3;
        e_ena = active && rows_left > 0 && !st;
        e_enb = e_ena && rows_left >= 2;
        ha[t] = e_ena;
        hb[t] = e_enb;
        chk("ena", fc_w_bram_ena, e_ena);
        chk("enb", fc_w_bram_enb, e_enb);
        if (e_ena) chk("addra", fc_w_bram_addra, (m_base + issued) % (1 << AW));
        if (e_enb) chk("addrb", fc_w_bram_addrb, (m_base + issued + 1) % (1 << AW));
        chk("valid_a", w_valid_a, t >= LAT ? ha[t-LAT] : 1'b0);
        chk("valid_b", w_valid_b, t >= LAT ? hb[t-LAT] : 1'b0);
        chk("busy", busy, active && (rows_left > 0 || t <= last_valid));
        chk("done", done, t == done_cycle);
        if (prev_rst) begin
            chk("rst_addra", fc_w_bram_addra, 0);
            chk("rst_addrb", fc_w_bram_addrb, 0);
        end
        lena[t] = fc_w_bram_ena; lenb[t] = fc_w_bram_enb; la[t] = fc_w_bram_addra; lb[t] = fc_w_bram_addrb;
        lva[t] = w_valid_a; lvb[t] = w_valid_b; ldone[t] = done; lbusy[t] = busy;
        @(posedge clk);
        #1;
        idle = !active && t != done_cycle;
        if (r) begin
            active = 0; rows_left = 0; done_cycle = -100; last_valid = -100;
            for (int i = 0; i < LAT; i++) if (t - i >= 0) begin ha[t-i] = 0; hb[t-i] = 0; end
        end else begin
            if (e_ena) begin
                k = e_enb ? 2 : 1;
                issued += k;
                rows_left -= k;
                if (rows_left == 0) begin last_valid = t + LAT; done_cycle = t + LAT + 1; end
            end
            if (t == done_cycle) active = 0;
            else if (idle && s) begin
                m_base = b;
                if (n > 0) begin active = 1; rows_left = n; issued = 0; last_valid = -100; end
                else done_cycle = t + 1;
            end
        end
        prev_rst = r;
        t++;
    endtask

    task automatic idle_n(input int c);
        for (int i = 0; i < c; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int t0;
        rst = 1; start = 0; stall = 0; base_addr = '0; row_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        // base 0, six rows
        t0 = t; step(0, 1, 0, 6, 0); idle_n(7);
        chk("l34_a1", la[t0+1], 0); chk("l34_a2", la[t0+2], 2); chk("l34_a3", la[t0+3], 4);
        chk("l34_b1", lb[t0+1], 1); chk("l34_b3", lb[t0+3], 5);
        chk("l34_v3", lva[t0+3] && lvb[t0+3], 1); chk("l34_v5", lva[t0+5] && lvb[t0+5], 1);
        chk("l34_v6", lva[t0+6], 0); chk("l34_d5", ldone[t0+5], 0); chk("l34_d6", ldone[t0+6], 1);
        // odd count
        t0 = t; step(0, 1, 10, 5, 0); idle_n(6);
        chk("l35_a", la[t0+3], 14); chk("l35_enb", lenb[t0+3], 0);
        chk("l35_va", lva[t0+5], 1); chk("l35_vb", lvb[t0+5], 0);
        // wraparound
        t0 = t; step(0, 1, 1023, 4, 0); idle_n(5);
        chk("l36_a1", la[t0+1], 1023); chk("l36_b1", lb[t0+1], 0);
        chk("l36_a2", la[t0+2], 1); chk("l36_b2", lb[t0+2], 2);
        // stall in cycles 2-3
        t0 = t; step(0, 1, 0, 8, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); idle_n(8);
        chk("l37_en2", lena[t0+2], 0); chk("l37_a4", la[t0+4], 2);
        chk("l37_d8", ldone[t0+8], 0); chk("l37_d9", ldone[t0+9], 1);
        // zero rows, then restart attempts while busy
        t0 = t; step(0, 1, 7, 0, 0); step(0, 1, 9, 5, 0); idle_n(2);
        chk("l38_d1", ldone[t0+1], 1); chk("l38_b1", lbusy[t0+1], 0); chk("l38_en", lena[t0+2], 0);
        step(0, 1, 100, 10, 0); step(0, 0, 0, 0, 0); step(0, 1, 500, 3, 0); idle_n(10);
        // reset mid-sweep with coincident start
        t0 = t; step(0, 1, 30, 20, 0); idle_n(3); step(1, 1, 5, 4, 0); idle_n(3);
        chk("l39_busy", lbusy[t0+5], 0);
        step(0, 1, 40, 7, 0); idle_n(8);
        for (int i = 0; i < 3000; i++)
            step($urandom % 100 == 0, $urandom % 6 == 0, int'($urandom % 1024),
                 ($urandom % 10 == 0) ? int'($urandom % 1025) : int'($urandom % 24), $urandom % 4 == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
